// File: rtl/result_quantizer.sv
// Bias-add, optional ReLU, round-half-up arithmetic shift and int16 saturation of a
// 32-bit accumulator stream; emits Output_Len+1 write strobes per frame, data one cycle later.
module result_quantizer #(
  parameter int ACC_W = 32,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [10:0]      Output_Len,
  input  logic [ACC_W-1:0] bias,
  input  logic [4:0]       shift,
  input  logic             relu_en,
  input  logic             acc_valid,
  input  logic [ACC_W-1:0] acc_data,
  output logic             acc_ready,
  output logic             Output_FIFO_wr_en,
  output logic [31:0]      Output_FIFO_din,
  output logic             busy,
  output logic             frame_done
);

  localparam int SUM_W = ACC_W + 1;
  localparam int RND_W = ACC_W + 2;
  localparam int UP_W  = RND_W - OUT_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t state_q, state_d;

  logic [ACC_W-1:0] bias_q;
  logic [4:0]       shift_q;
  logic             relu_q;
  logic [10:0]      len_q;
  logic [10:0]      cnt_q;
  logic             load_cfg;
  logic             accept;

  logic                    s1_v, s2_v, s3_v;
  logic signed [SUM_W-1:0] s1_sum;
  logic signed [RND_W-1:0] s2_val;
  logic [OUT_W-1:0]        s3_q;

  logic signed [SUM_W-1:0] relu_v;
  logic signed [RND_W-1:0] rnd_inc, rnd_sum, rnd_shifted;
  logic [UP_W-1:0]         s2_upper;
  logic [OUT_W-1:0]        sat_v;

  // Handshake: acc_data is consumed on every rising edge where acc_valid && acc_ready;
  // acc_ready depends only on state (never on acc_valid) and the producer may hold or drop valid freely.
  assign accept = acc_valid & acc_ready;

  always_comb begin
    state_d    = state_q;
    acc_ready  = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    load_cfg   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load_cfg = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_ready = 1'b1;
        busy      = 1'b1;
        if (acc_valid && (cnt_q == len_q)) state_d = FLUSH;
      end
      FLUSH: begin
        busy = 1'b1;
        // The data register loads on the edge that retires s3, so an empty pipe means din is final.
        if (!s1_v && !s2_v && !s3_v) state_d = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bias_q  <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load_cfg) begin
        bias_q  <= bias;
        shift_q <= shift;
        relu_q  <= relu_en;
        len_q   <= Output_Len;
        cnt_q   <= '0;
      end else if (accept) begin
        cnt_q <= cnt_q + 11'd1;
      end
    end
  end

  always_comb begin
    relu_v = s1_sum;
    if (relu_q && s1_sum[SUM_W-1]) relu_v = '0;
    rnd_inc = '0;
    if (shift_q != 5'd0) rnd_inc = RND_W'(1) << (shift_q - 5'd1);
    rnd_sum     = {relu_v[SUM_W-1], relu_v} + rnd_inc;
    rnd_shifted = rnd_sum >>> shift_q;
  end

  // The value fits int16 exactly when every bit from the int16 sign bit upward agrees.
  always_comb begin
    s2_upper = s2_val[RND_W-1:OUT_W-1];
    sat_v    = s2_val[OUT_W-1:0];
    if (!((&s2_upper) || (~|s2_upper))) begin
      sat_v = s2_upper[UP_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v            <= 1'b0;
      s2_v            <= 1'b0;
      s3_v            <= 1'b0;
      s1_sum          <= '0;
      s2_val          <= '0;
      s3_q            <= '0;
      Output_FIFO_din <= '0;
    end else begin
      s1_v <= accept;
      s2_v <= s1_v;
      s3_v <= s2_v;
      if (accept) s1_sum <= {acc_data[ACC_W-1], acc_data} + {bias_q[ACC_W-1], bias_q};
      if (s1_v)   s2_val <= rnd_shifted;
      if (s2_v)   s3_q   <= sat_v;
      if (s3_v)   Output_FIFO_din <= {{(32-OUT_W){s3_q[OUT_W-1]}}, s3_q};
    end
  end

  assign Output_FIFO_wr_en = s3_v;

endmodule

// File: doc/result_quantizer.md
# result_quantizer

Post-processing stage directly upstream of the output write-back FIFO/AXI-HP writer. Accepts a stream of 32-bit signed accumulator results from the convolution/FC datapath; adds a per-frame bias, applies optional ReLU, rounds by an arithmetic right shift and saturates to int16. Emits exactly Output_Len+1 words per frame on the Output_FIFO write port, with the data/enable phase relationship that the write-back stage requires.

## Interface
Parameters:
- ACC_W, 32, accumulator input width (signed)
- OUT_W, 16, quantized result width (signed)

Ports:
- clk  in  1  single clock for all logic
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; latches config and begins a frame (ignored while busy)
- Output_Len  in  11  words per frame minus one (same encoding as the write-back stage)
- bias  in  32  signed bias, latched at start
- shift  in  5  right-shift amount 0..31, latched at start
- relu_en  in  1  1 = clamp negatives to 0, latched at start
- acc_valid  in  1  accumulator word valid
- acc_data  in  32  signed accumulator word
- acc_ready  out  1  block accepts acc_data this cycle
- Output_FIFO_wr_en  out  1  write strobe to write-back stage
- Output_FIFO_din  out  32  quantized word, bits [15:0] result, [31:16] sign extension
- busy  out  1  frame in progress (RUN or FLUSH)
- frame_done  out  1  one-cycle pulse when the frame's last word has been presented

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE: start=1 -> latch bias/shift/relu_en/Output_Len, clear input count, go RUN.
- RUN: acc_ready=1. Word accepted when acc_valid & acc_ready. Count accepted words; on acceptance of word Output_Len (i.e. the (Output_Len+1)-th), acc_ready drops the next cycle, go FLUSH.
- FLUSH: acc_ready=0; wait until the pipeline is empty and the last din update has occurred, go DONE.
- DONE: frame_done=1 for one cycle, go IDLE.
- Pipeline (per accepted word, all stages registered):
  - S1: sum = sext33(acc_data) + sext33(bias); no overflow possible.
  - S2: if relu_en and sum<0 then v=0; else v=sum. If shift>0: v = (v + 2^(shift-1)) >>> shift (arithmetic, round half up, 34-bit intermediate); shift=0: v unchanged.
  - S3: saturate v to [-32768, 32767]; assert Output_FIFO_wr_en for one cycle.
  - Data register: Output_FIFO_din loads the S3 result on the cycle AFTER its wr_en pulse and holds until the next load.
- Input count wraps never: exactly Output_Len+1 words accepted; acc_valid outside RUN is ignored (no pulse, no count).
- Output_Len=0: one word per frame.
- start during RUN/FLUSH/DONE ignored; start in the same cycle as DONE ignored.
- No backpressure from downstream; the downstream FIFO is sized for a full frame.

## Timing
- Reset values: acc_ready=0, Output_FIFO_wr_en=0, Output_FIFO_din=0, busy=0, frame_done=0, state IDLE, all pipeline valids cleared.
- start at cycle 0 -> RUN and acc_ready=1 from cycle 1.
- Word accepted at cycle t -> Output_FIFO_wr_en=1 at t+3 -> Output_FIFO_din valid from t+4.
- Throughput one word/cycle; back-to-back inputs yield back-to-back wr_en pulses, each din value stable in the cycle following its pulse.
- Last word accepted at t_L -> acc_ready=0 at t_L+1; last din update at t_L+4; frame_done at t_L+5; busy=0 and start accepted from t_L+6.
- Async reset mid-frame: all outputs to reset values immediately; partial frame discarded; no frame_done.

## Test plan
- Basic frame: shift=0, bias=0, relu_en=0, Output_Len=3, inputs 1,-2,3,-4 back-to-back -> 4 wr_en pulses at t+3.., din 0x00000001, 0xFFFFFFFE, 0x00000003, 0xFFFFFFFC each at pulse+1; frame_done at t_L+5.
- Rounding/ReLU: bias=10, shift=2, relu_en=1, inputs 0, -20, 5, 6 -> din 3 (10+2>>2), 0, 4 (15+2>>2), 4 (16+2>>2).
- Saturation: shift=0, bias=0, inputs 40000, -40000, 0x7FFFFFFF with bias=1 -> din 0x00007FFF, 0xFFFF8000, 0x00007FFF (no 33-bit wrap).
- Gapped input and extra words: Output_Len=2, acc_valid toggling every other cycle, then 3 extra valid words -> exactly 3 pulses, acc_ready=0 after third acceptance, extras unaccepted.
- Config protection: start pulsed mid-frame with different bias -> ignored, results use original bias; Output_Len=0 -> single pulse and frame_done.
- Reset mid-frame after 2 of 8 words -> all outputs 0 immediately, no frame_done; new start completes a full 8-word frame correctly.
